// File: rtl/sequencer_if.sv
// Sequencer port bundle: instruction fields and load data in,
// store/ALU stream and status out, plus completion acknowledges.
interface sequencer_if;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic [2:0]  lmul;
    logic [2:0]  vsew;
    logic [31:0] vl;
    logic [15:0] var_dec_bits;
    logic [31:0] ld_data;
    logic        rw_done;
    logic        w_done;
    logic        vseq_busy;
    logic [2:0]  vid;
    logic [31:0] out_data;
    logic        out_valid;

    modport master (
        output vs1, vs2, vd, lmul, vsew, vl, var_dec_bits,
        output ld_data, rw_done, w_done,
        input  vseq_busy, vid, out_data, out_valid
    );

    modport slave (
        input  vs1, vs2, vd, lmul, vsew, vl, var_dec_bits,
        input  ld_data, rw_done, w_done,
        output vseq_busy, vid, out_data, out_valid
    );
endinterface

// File: rtl/sequencer.sv
// Vector sequencer: decodes a vector op, owns the VRF and streams
// one 32-bit element per cycle for load, store or element-wise ALU.
module sequencer #(
    parameter int VLEN = 128,
    parameter int NREG = 32
) (
    input  logic clk,
    input  logic nrst,
    sequencer_if.slave bus
);
    localparam int EPR = VLEN / 32;
    localparam int SW  = (EPR > 1) ? $clog2(EPR) : 1;
    localparam int RW  = $clog2(NREG);
    localparam int EW  = $clog2(EPR * 8) + 1;

    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
    typedef enum logic [1:0] {K_LOAD, K_STORE, K_ARITH} kind_t;
    typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_XOR} alu_t;

    state_t state_q, state_d;
    kind_t  kind_q, kind_d;
    alu_t   alu_q, alu_d;

    logic [4:0]    vd_q, vs1_q, vs2_q;
    logic [EW-1:0] n_q, e_q, n_acc, grp;
    logic [30:0]   last_q, tuple;
    logic          last_v;

    logic [6:0]  opc;
    logic [5:0]  funct6;
    logic        is_ld, is_st, is_ar, f_ok, op_ok;
    logic        accept, ack;
    logic [1:0]  lmul_eff;
    logic [31:0] vlmax;

    logic [31:0] vrf [NREG][EPR];
    logic [SW-1:0] slot;
    logic [RW-1:0] rd_idx, r1_idx, r2_idx;
    logic [31:0] op_a, op_b, st_rd, result;

    function automatic logic [RW-1:0] ridx(
        input logic [4:0] base,
        input logic [EW-1:0] g
    );
        return RW'((32'(base) + 32'(g)) % NREG);
    endfunction

    assign opc    = bus.var_dec_bits[6:0];
    assign funct6 = bus.var_dec_bits[15:10];
    assign is_ld  = (opc == 7'b0000111);
    assign is_st  = (opc == 7'b0100111);
    assign is_ar  = (opc == 7'b1010111);
    assign tuple  = {bus.var_dec_bits, bus.vd, bus.vs1, bus.vs2};

    always_comb begin
        alu_d = A_ADD;
        f_ok  = 1'b1;
        unique case (funct6)
            6'b000000: alu_d = A_ADD;
            6'b000010: alu_d = A_SUB;
            6'b001001: alu_d = A_AND;
            6'b001010: alu_d = A_OR;
            6'b001011: alu_d = A_XOR;
            default:   f_ok  = 1'b0;
        endcase
    end

    always_comb begin
        kind_d = K_LOAD;
        op_ok  = 1'b0;
        unique case (1'b1)
            is_ld:   begin kind_d = K_LOAD;  op_ok = 1'b1; end
            is_st:   begin kind_d = K_STORE; op_ok = 1'b1; end
            is_ar:   begin kind_d = K_ARITH; op_ok = f_ok; end
            default: op_ok = 1'b0;
        endcase
    end

    // lmul encodings 4..7 behave as a single-register group
    assign lmul_eff = bus.lmul[2] ? 2'd0 : bus.lmul[1:0];
    assign vlmax    = 32'(EPR) << lmul_eff;
    assign n_acc    = EW'((bus.vl < vlmax) ? bus.vl : vlmax);

    assign accept = (state_q == IDLE) && op_ok
                 && (bus.vsew == 3'b010)
                 && (!last_v || tuple != last_q);
    assign ack = (kind_q == K_ARITH) ? bus.w_done : bus.rw_done;

    always_ff @(posedge clk) begin
        if (nrst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (n_acc == '0) ? WAIT : RUN;
            RUN:     if (e_q == n_q - EW'(1)) state_d = WAIT;
            WAIT:    if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            e_q    <= '0;
            n_q    <= '0;
            vd_q   <= '0;
            vs1_q  <= '0;
            vs2_q  <= '0;
            kind_q <= K_LOAD;
            alu_q  <= A_ADD;
            last_q <= '0;
            last_v <= 1'b0;
        end else if (accept) begin
            e_q    <= '0;
            n_q    <= n_acc;
            vd_q   <= bus.vd;
            vs1_q  <= bus.vs1;
            vs2_q  <= bus.vs2;
            kind_q <= kind_d;
            alu_q  <= alu_d;
            last_q <= tuple;
            last_v <= 1'b1;
        end else if (state_q == RUN) begin
            e_q <= e_q + EW'(1);
        end
    end

    assign grp    = e_q >> SW;
    assign slot   = e_q[SW-1:0];
    assign rd_idx = ridx(vd_q, grp);
    assign r1_idx = ridx(vs1_q, grp);
    assign r2_idx = ridx(vs2_q, grp);
    assign op_a   = vrf[r2_idx][slot];
    assign op_b   = vrf[r1_idx][slot];
    assign st_rd  = vrf[rd_idx][slot];

    always_comb begin
        result = '0;
        unique case (alu_q)
            A_ADD:   result = op_a + op_b;
            A_SUB:   result = op_a - op_b;
            A_AND:   result = op_a & op_b;
            A_OR:    result = op_a | op_b;
            A_XOR:   result = op_a ^ op_b;
            default: result = '0;
        endcase
    end

    // VRF has no reset; reads in the write cycle see the old value
    always_ff @(posedge clk) begin
        if (!nrst && state_q == RUN && kind_q != K_STORE)
            vrf[rd_idx][slot] <= (kind_q == K_LOAD) ? bus.ld_data : result;
    end

    always_comb begin
        bus.vseq_busy = (state_q != IDLE);
        bus.vid       = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        if (state_q == RUN) begin
            bus.vid       = grp[2:0];
            bus.out_valid = (kind_q != K_LOAD);
            if (kind_q == K_STORE)      bus.out_data = st_rd;
            else if (kind_q == K_ARITH) bus.out_data = result;
        end
    end
endmodule

// File: tb/tb_sequencer.sv
// Scoreboard bench for the vector sequencer: a VRF model predicts
// every streamed element; expectations are queued then compared.
module tb_sequencer;
    logic clk;
    logic nrst;
    int   passed;
    int   total;
    logic [31:0] mdl [32][4];
    logic [31:0] exp_q [$];

    sequencer_if sif ();

    sequencer dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int ridx(input int base, input int e);
        return (base + e / 4) % 32;
    endfunction

    function automatic logic [31:0] alu_model(
        input logic [5:0] f, input logic [31:0] a, input logic [31:0] b
    );
        case (f)
            6'd0:    return a + b;
            6'd2:    return a - b;
            6'd9:    return a & b;
            6'd10:   return a | b;
            6'd11:   return a ^ b;
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic set_op(
        input logic [15:0] dec, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2,
        input logic [2:0] lm, input logic [31:0] len
    );
        sif.var_dec_bits = dec;
        sif.vd   = d;
        sif.vs1  = s1;
        sif.vs2  = s2;
        sif.lmul = lm;
        sif.vl   = len;
        sif.vsew = 3'b010;
    endtask

    task automatic pulse_ack(input bit arith);
        if (arith) sif.w_done = 1'b1;
        else       sif.rw_done = 1'b1;
        tick;
        sif.w_done  = 1'b0;
        sif.rw_done = 1'b0;
    endtask

    task automatic test_reset;
        nrst = 1'b1;
        repeat (2) tick;
        nrst = 1'b0;
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", sif.vseq_busy); else passed++;
        total++; if (sif.vid !== 3'd0) $display("FAIL rst_vid got %0d want 0", sif.vid); else passed++;
        total++; if (sif.out_valid !== 1'b0) $display("FAIL rst_ovalid got %0b want 0", sif.out_valid); else passed++;
        total++; if (sif.out_data !== 32'd0) $display("FAIL rst_odata got %0h want 0", sif.out_data); else passed++;
        set_op(16'h0007, 5'd8, 5'd0, 5'd0, 3'd3, 32'd32);
        tick;
        total++; if (sif.vseq_busy !== 1'b1) $display("FAIL pre_abort_busy got %0b want 1", sif.vseq_busy); else passed++;
        for (int e = 0; e < 6; e++) begin
            sif.ld_data = 32'(100 + e);
            mdl[ridx(8, e)][e % 4] = 32'(100 + e);
            tick;
        end
        nrst = 1'b1;
        tick;
        nrst = 1'b0;
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", sif.vseq_busy); else passed++;
        total++; if (sif.vid !== 3'd0) $display("FAIL abort_vid got %0d want 0", sif.vid); else passed++;
        total++; if (sif.out_valid !== 1'b0) $display("FAIL abort_ovalid got %0b want 0", sif.out_valid); else passed++;
    endtask

    task automatic test_load;
        tick;
        total++; if (sif.vseq_busy !== 1'b1) $display("FAIL reaccept_busy got %0b want 1", sif.vseq_busy); else passed++;
        for (int e = 0; e < 32; e++) begin
            total++; if (sif.vid !== 3'(e / 4)) $display("FAIL load_vid e=%0d got %0d want %0d", e, sif.vid, e / 4); else passed++;
            sif.ld_data = 32'(e + 1);
            mdl[ridx(8, e)][e % 4] = 32'(e + 1);
            tick;
        end
        total++; if (sif.vid !== 3'd0) $display("FAIL wait_vid got %0d want 0", sif.vid); else passed++;
        sif.w_done = 1'b1;
        repeat (2) tick;
        sif.w_done = 1'b0;
        total++; if (sif.vseq_busy !== 1'b1) $display("FAIL load_wait_busy got %0b want 1", sif.vseq_busy); else passed++;
        pulse_ack(1'b0);
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL load_done_busy got %0b want 0", sif.vseq_busy); else passed++;
    endtask

    task automatic test_load_store;
        set_op(16'h0007, 5'd16, 5'd0, 5'd0, 3'd3, 32'd32);
        tick;
        total++; if (sif.vseq_busy !== 1'b1) $display("FAIL vd_change_busy got %0b want 1", sif.vseq_busy); else passed++;
        for (int e = 0; e < 32; e++) begin
            sif.ld_data = -32'(e + 1);
            mdl[ridx(16, e)][e % 4] = -32'(e + 1);
            tick;
        end
        pulse_ack(1'b0);
        set_op(16'h0027, 5'd16, 5'd0, 5'd0, 3'd3, 32'd32);
        tick;
        for (int e = 0; e < 32; e++) begin
            logic [31:0] x;
            exp_q.push_back(mdl[ridx(16, e)][e % 4]);
            total++; if (sif.out_valid !== 1'b1) $display("FAIL st_ovalid e=%0d got %0b want 1", e, sif.out_valid); else passed++;
            x = exp_q.pop_front();
            total++; if (sif.out_data !== x) $display("FAIL st_data e=%0d got %0h want %0h", e, sif.out_data, x); else passed++;
            tick;
        end
        total++; if (sif.out_valid !== 1'b0) $display("FAIL st_wait_ovalid got %0b want 0", sif.out_valid); else passed++;
        pulse_ack(1'b0);
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL st_done_busy got %0b want 0", sif.vseq_busy); else passed++;
    endtask

    task automatic test_arith;
        set_op(16'h0057, 5'd16, 5'd8, 5'd16, 3'd3, 32'd32);
        tick;
        for (int e = 0; e < 32; e++) begin
            logic [31:0] x;
            x = alu_model(6'd0, mdl[ridx(16, e)][e % 4], mdl[ridx(8, e)][e % 4]);
            exp_q.push_back(x);
            mdl[ridx(16, e)][e % 4] = x;
            x = exp_q.pop_front();
            total++; if (sif.out_valid !== 1'b1 || sif.out_data !== x) $display("FAIL vadd e=%0d got %0b/%0h want 1/%0h", e, sif.out_valid, sif.out_data, x); else passed++;
            tick;
        end
        pulse_ack(1'b0);
        total++; if (sif.vseq_busy !== 1'b1) $display("FAIL arith_rwdone_busy got %0b want 1", sif.vseq_busy); else passed++;
        pulse_ack(1'b1);
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL arith_done_busy got %0b want 0", sif.vseq_busy); else passed++;
    endtask

    task automatic test_clamp;
        set_op(16'h0027, 5'd8, 5'd0, 5'd0, 3'd0, 32'd5);
        tick;
        for (int e = 0; e < 4; e++) begin
            logic [31:0] x;
            exp_q.push_back(mdl[ridx(8, e)][e % 4]);
            x = exp_q.pop_front();
            total++; if (sif.out_valid !== 1'b1 || sif.out_data !== x) $display("FAIL clamp e=%0d got %0b/%0h want 1/%0h", e, sif.out_valid, sif.out_data, x); else passed++;
            tick;
        end
        total++; if (sif.out_valid !== 1'b0) $display("FAIL clamp_len got %0b want 0", sif.out_valid); else passed++;
        total++; if (sif.vseq_busy !== 1'b1) $display("FAIL clamp_wait got %0b want 1", sif.vseq_busy); else passed++;
        pulse_ack(1'b0);
        set_op(16'h0027, 5'd9, 5'd0, 5'd0, 3'd0, 32'd0);
        tick;
        total++; if (sif.vseq_busy !== 1'b1 || sif.out_valid !== 1'b0) $display("FAIL vl0_wait got %0b/%0b want 1/0", sif.vseq_busy, sif.out_valid); else passed++;
        pulse_ack(1'b0);
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL vl0_done got %0b want 0", sif.vseq_busy); else passed++;
    endtask

    task automatic test_reject;
        repeat (2) tick;
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL rej_same got %0b want 0", sif.vseq_busy); else passed++;
        set_op(16'h0027, 5'd10, 5'd0, 5'd0, 3'd0, 32'd4);
        sif.vsew = 3'b011;
        tick;
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL rej_vsew got %0b want 0", sif.vseq_busy); else passed++;
        set_op(16'h0033, 5'd10, 5'd0, 5'd0, 3'd0, 32'd4);
        tick;
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL rej_opc got %0b want 0", sif.vseq_busy); else passed++;
        set_op(16'h0457, 5'd10, 5'd0, 5'd0, 3'd0, 32'd4);
        tick;
        total++; if (sif.vseq_busy !== 1'b0) $display("FAIL rej_f6 got %0b want 0", sif.vseq_busy); else passed++;
    endtask

    task automatic test_wrap;
        set_op(16'h0007, 5'd30, 5'd0, 5'd0, 3'd2, 32'd16);
        tick;
        for (int e = 0; e < 16; e++) begin
            logic [31:0] r;
            r = $urandom;
            sif.ld_data = r;
            mdl[ridx(30, e)][e % 4] = r;
            tick;
        end
        pulse_ack(1'b0);
        set_op(16'h0027, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4);
        tick;
        for (int e = 0; e < 4; e++) begin
            logic [31:0] x;
            exp_q.push_back(mdl[0][e]);
            x = exp_q.pop_front();
            total++; if (sif.out_data !== x) $display("FAIL wrap_reg0 e=%0d got %0h want %0h", e, sif.out_data, x); else passed++;
            tick;
        end
        pulse_ack(1'b0);
    endtask

    task automatic test_alu_ops;
        logic [5:0] ops [5];
        ops = '{6'd2, 6'd9, 6'd10, 6'd11, 6'd0};
        foreach (ops[k]) begin
            logic [4:0] s1;
            s1 = (ops[k] == 6'd2) ? 5'd16 : 5'd30;
            set_op({ops[k], 3'b000, 7'b1010111}, 5'd24, s1, 5'd8, 3'd2, 32'd16);
            tick;
            for (int e = 0; e < 16; e++) begin
                logic [31:0] x;
                x = alu_model(ops[k], mdl[ridx(8, e)][e % 4], mdl[ridx(int'(s1), e)][e % 4]);
                exp_q.push_back(x);
                mdl[ridx(24, e)][e % 4] = x;
                x = exp_q.pop_front();
                total++; if (sif.out_data !== x) $display("FAIL alu f6=%0d e=%0d got %0h want %0h", ops[k], e, sif.out_data, x); else passed++;
                tick;
            end
            pulse_ack(1'b1);
            total++; if (sif.vseq_busy !== 1'b0) $display("FAIL alu_done f6=%0d got %0b want 0", ops[k], sif.vseq_busy); else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        nrst   = 1'b1;
        sif.vs1 = '0;
        sif.vs2 = '0;
        sif.vd  = '0;
        sif.lmul = '0;
        sif.vsew = 3'b010;
        sif.vl   = '0;
        sif.var_dec_bits = '0;
        sif.ld_data = '0;
        sif.rw_done = 1'b0;
        sif.w_done  = 1'b0;
        test_reset;
        test_load;
        test_load_store;
        test_arith;
        test_clamp;
        test_reject;
        test_wrap;
        test_alu_ops;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Vector-unit sequencer for the RISC-V tensor core.
- Decodes a vector instruction word and owns the vector register file (VRF): 32 registers × VLEN bits, 32-bit elements.
- Streams one element per clock through a register group: load data in, store data out, or element-wise ALU results written back.
- Sits between the scalar issue/decode stage and the load/store and ALU datapaths.

Parameters:
- VLEN, 128, bits per vector register; EPR = VLEN/32 elements per register (4 by default).
- NREG, 32, number of vector registers; register index wraps modulo NREG.

Ports:
- clk  in  1  clock; all logic on rising edge.
- nrst  in  1  reset, synchronous, active-high.
- vseq_busy  out  1  high while an operation is running or awaiting acknowledge.
- vs1  in  5  source register group base 1.
- vs2  in  5  source register group base 2.
- vd  in  5  destination base for load/arith; source base for store.
- lmul  in  3  group size: 0..3 selects 1/2/4/8 registers; 4..7 treated as 0.
- vsew  in  3  element width; only 3'b010 (32-bit) is accepted.
- vl  in  32  requested element count.
- var_dec_bits  in  16  instruction fields: [6:0] opcode, [9:7] funct3, [15:10] funct6.
- ld_data  in  32  load element, sampled every RUN cycle of a load.
- vid  out  3  register offset within the group of the current element (element index / EPR).
- rw_done  in  1  load/store completion acknowledge.
- w_done  in  1  arithmetic completion acknowledge.
- out_data  out  32  store element, or arithmetic result element.
- out_valid  out  1  out_data valid (RUN cycles of store/arith only).

Behaviour:
- Opcodes: 7'b0000111 load; 7'b0100111 store; 7'b1010111 arith.
- Arith funct6: 000000 vadd (vs2+vs1); 000010 vsub (vs2−vs1); 001001 and; 001010 or; 001011 xor. Any other funct6 is not accepted.
- Acceptance: only in IDLE. Requires a supported opcode/funct6, vsew == 3'b010, and the tuple {var_dec_bits, vd, vs1, vs2} differing from the last accepted tuple.
  - After reset no prior tuple exists, so the first valid op is always accepted.
  - Fields are captured on the accepting edge; input changes after that are ignored until IDLE.
- States: IDLE → RUN → WAIT → IDLE.
- IDLE → RUN on the accepting edge.
  - If N = 0, go directly IDLE → WAIT instead.
- Element count: N = min(vl, EPR << lmul_eff).
- RUN lasts exactly N cycles, element e = 0..N−1, one element per cycle.
  - Register index = (base + e/EPR) mod NREG; slot = e mod EPR.
  - vid = e/EPR.
- Load: VRF[vd+vid][slot] <= ld_data sampled that cycle.
- Store: out_data = VRF[vd+vid][slot] combinationally; out_valid = 1.
- Arith: result = op(VRF[vs2+vid][slot], VRF[vs1+vid][slot]); written to VRF[vd+vid][slot] at the clock edge; out_data = result; out_valid = 1.
  - Arithmetic is modulo 2^32; no flags.
- Read-during-write: a read of a slot being written in the same cycle returns the old value.
- WAIT: hold until the acknowledge is sampled high — rw_done for load/store, w_done for arith — then IDLE.
  - An acknowledge already high on WAIT entry completes WAIT in one cycle.
  - An acknowledge asserted during RUN or IDLE is ignored.
- vseq_busy = 1 in RUN and WAIT, 0 in IDLE.
  - It rises the cycle after acceptance and falls the cycle after the acknowledge is sampled.
- vid = 0 in IDLE/WAIT; out_valid = 0 and out_data = 0 outside RUN.
- Reset (including mid-operation):
  - State → IDLE; vseq_busy, vid, out_valid, out_data → 0; last-tuple cleared.
  - Aborted ops leave partially written VRF contents; VRF is not reset.

Test Plan:
- Reset mid-RUN of a load (nrst high for 1 clk) -> next cycle vseq_busy=0, vid=0, out_valid=0; the same op is re-accepted afterwards.
- Load vd=8, lmul=3, vl=32, ld_data=1..32 over 32 cycles -> vid steps 0..7 every 4 cycles; VRF[8..15] holds 1..32.
  - Busy stays high in WAIT until rw_done; falls one cycle after rw_done is sampled.
- Load vd=16 with ld_data −1..−32 -> accepted because vd changed, even with identical var_dec_bits.
  - Then store vd=16 -> out_valid for 32 cycles with out_data −1..−32.
- Arith 16'h0057 (vadd), vs1=8, vs2=16, vd=16 -> out_data=0 for all 32 elements; VRF[16..23] all zero.
  - Busy holds until w_done; rw_done alone does not release it.
- vl=5, lmul=0 -> N=4 (clamped to VLMAX); vl=0 -> RUN skipped, WAIT entered directly.
- Rejects: vsew=3'b011, opcode 7'b0110011, or an unchanged tuple after completion -> no acceptance, vseq_busy stays 0.
- Register wrap: vd=30, lmul=2 -> writes go to registers 30, 31, 0, 1.
